// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   INSTR_W      : instruction / address width
//   RESET_PC_DEF : default fetch address after reset
//   DROP_W       : width of the stale-response drop counter. Outstanding
//                  requests are bounded by the memory pipeline depth, not by
//                  DEPTH, because new requests may issue while stale
//                  responses are still in flight.
//   slot_t       : one queue entry (filled flag, PC+4, instruction)
package fetch_queue_pkg;

  localparam int unsigned  INSTR_W      = 32;
  localparam logic [31:0]  RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned  DROP_W       = 8;

  typedef struct packed {
    logic                filled;
    logic [INSTR_W-1:0]  pc4;
    logic [INSTR_W-1:0]  instr;
  } slot_t;

endpackage

// File: rtl/fetch_queue_ring.sv
// In-order slot ring for fetched instructions. A slot is reserved at issue
// time (alloc, stores PC+4), completed when the response returns (fill,
// stores the word) and released when IF/ID consumes it (pop).
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   flush_i                  drop every slot and reset the pointers
//   alloc_i / alloc_pc4_i    reserve the next slot with this PC+4
//   fill_i / fill_instr_i    complete the oldest reserved slot
//   pop_i                    release the head slot
//   head_valid_o             head slot is filled
//   head_pc4_o/head_instr_o  head slot contents
//   occ_o                    reserved + filled slots
//   pend_o                   reserved slots still waiting for data
module fetch_queue_ring
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               alloc_i,
  input  logic [INSTR_W-1:0] alloc_pc4_i,
  input  logic               fill_i,
  input  logic [INSTR_W-1:0] fill_instr_i,
  input  logic               pop_i,
  output logic               head_valid_o,
  output logic [INSTR_W-1:0] head_pc4_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [CW-1:0]      occ_o,
  output logic [CW-1:0]      pend_o
);

  slot_t          slots_q [DEPTH];
  logic [PW-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]  fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0]  head_ptr_q,  head_ptr_d;
  logic [CW-1:0]  occ_q,  occ_d;
  logic [CW-1:0]  pend_q, pend_d;

  always_comb begin
    alloc_ptr_d = alloc_ptr_q + PW'(alloc_i);
    fill_ptr_d  = fill_ptr_q  + PW'(fill_i);
    head_ptr_d  = head_ptr_q  + PW'(pop_i);
    occ_d       = occ_q  + CW'(alloc_i) - CW'(pop_i);
    pend_d      = pend_q + CW'(alloc_i) - CW'(fill_i);
  end

  // The alloc, fill and head slots are always distinct when their strobes
  // are active (alloc targets a free slot, fill a reserved one, pop a
  // filled one), so the three writes below never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
      for (int i = 0; i < DEPTH; i++) slots_q[i].filled <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      if (alloc_i) begin
        slots_q[alloc_ptr_q].pc4    <= alloc_pc4_i;
        slots_q[alloc_ptr_q].filled <= 1'b0;
      end
      if (fill_i) begin
        slots_q[fill_ptr_q].instr  <= fill_instr_i;
        slots_q[fill_ptr_q].filled <= 1'b1;
      end
      if (pop_i) slots_q[head_ptr_q].filled <= 1'b0;
    end
  end

  assign head_valid_o = slots_q[head_ptr_q].filled;
  assign head_pc4_o   = slots_q[head_ptr_q].pc4;
  assign head_instr_o = slots_q[head_ptr_q].instr;
  assign occ_o        = occ_q;
  assign pend_o       = pend_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word fetches to
// instruction memory, buffers returned words with their PC+4 and presents one
// instruction per cycle to IF/ID. Branch redirects flush the queue; responses
// to requests issued before the redirect are counted and discarded.
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   imem_req_o / imem_addr_o       fetch request and word address
//   imem_ready_i                   memory accepts (req & ready = issue)
//   imem_rvalid_i / imem_rdata_i   in-order read response
//   stall_i                        IF/ID holds, head not consumed
//   redirect_i / redirect_pc_i     flush and refetch from redirect_pc_i
//   if_valid_o, if_instr_o, if_pc4_o  head instruction to IF/ID
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [INSTR_W-1:0] imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [INSTR_W-1:0] redirect_pc_i,
  output logic               if_valid_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [INSTR_W-1:0] if_pc4_o
);

  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [DROP_W-1:0]  outstanding;
  logic [CW-1:0]      occ, pend;
  logic               head_valid;
  logic [INSTR_W-1:0] head_pc4, head_instr;
  logic               issue, fill, pop, resp_drop;

  assign outstanding = DROP_W'(pend) + drop_cnt_q;
  assign imem_req_o  = (occ < CW'(DEPTH)) && !redirect_i && !rst_i;
  assign imem_addr_o = pc_q;
  assign issue       = imem_req_o && imem_ready_i;
  // Stale responses always precede live ones, so they are consumed first.
  assign resp_drop   = imem_rvalid_i && (drop_cnt_q != '0);
  assign fill        = imem_rvalid_i && !redirect_i && (drop_cnt_q == '0) && (pend != '0);
  assign pop         = head_valid && !stall_i && !redirect_i;

  always_comb begin
    pc_d       = pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
      // A response arriving in the redirect cycle is itself discarded.
      drop_cnt_d = outstanding - DROP_W'(imem_rvalid_i && (outstanding != '0));
    end else begin
      if (issue)     pc_d       = pc_q + 32'd4;
      if (resp_drop) drop_cnt_d = drop_cnt_q - DROP_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_queue_ring #(.DEPTH(DEPTH)) u_ring (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_i),
    .alloc_i      (issue),
    .alloc_pc4_i  (pc_q + 32'd4),
    .fill_i       (fill),
    .fill_instr_i (imem_rdata_i),
    .pop_i        (pop),
    .head_valid_o (head_valid),
    .head_pc4_o   (head_pc4),
    .head_instr_o (head_instr),
    .occ_o        (occ),
    .pend_o       (pend)
  );

  assign if_valid_o = head_valid && !rst_i;
  assign if_instr_o = if_valid_o ? head_instr : '0;
  assign if_pc4_o   = if_valid_o ? head_pc4   : '0;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && imem_rvalid_i)
      assert (outstanding != '0)
        else $error("fetch_queue: imem_rvalid with no request outstanding");
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk_i = 1'b0;
  logic        rst_i, imem_req_o, imem_ready_i, imem_rvalid_i, stall_i, redirect_i, if_valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, if_instr_o, if_pc4_o;

  always #5 clk_i = ~clk_i;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc4_o(if_pc4_o)
  );

  int errors = 0, checks = 0;
  int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;

  // Reference model: requests in flight (live = not cancelled by a redirect),
  // and the in-order list of returned addresses waiting for IF/ID.
  typedef struct { logic [31:0] addr; bit live; } infl_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  infl_t       m_inf[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_pc = RST_PC;
  mreq_t       mem_q[$];

  logic        o_req, o_valid, o_rv;
  logic [31:0] o_addr, o_instr, o_pc4;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle(input bit r, input bit s, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit rv, exp_req, issue;
    int occ, due;
    infl_t f;
    rst_i = r; stall_i = s; redirect_i = rd; redirect_pc_i = rpc; imem_ready_i = rdy;
    rv = !r && mem_q.size() > 0 && mem_q[0].due <= cyc;
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? data_of(mem_q[0].addr) : $urandom;
    occ = m_buf.size();
    foreach (m_inf[i]) if (m_inf[i].live) occ++;
    exp_req = !r && !rd && occ < DEPTH;
    @(negedge clk_i);
    o_req = imem_req_o; o_addr = imem_addr_o; o_valid = if_valid_o;
    o_instr = if_instr_o; o_pc4 = if_pc4_o; o_rv = rv;
    chk("req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (exp_req) chk("addr", imem_addr_o, m_pc);
    if (r) begin
      chk("rst_valid", {31'b0, if_valid_o}, 32'h0);
      chk("rst_instr", if_instr_o, 32'h0);
      chk("rst_pc4", if_pc4_o, 32'h0);
    end else begin
      chk("valid", {31'b0, if_valid_o}, {31'b0, m_buf.size() > 0});
      if (m_buf.size() > 0) begin
        chk("instr", if_instr_o, data_of(m_buf[0]));
        chk("pc4", if_pc4_o, m_buf[0] + 32'd4);
      end
    end
    @(posedge clk_i);
    if (r) begin
      m_inf.delete(); m_buf.delete(); mem_q.delete();
      m_pc = RST_PC; last_due = 0;
    end else begin
      issue = exp_req && rdy;
      if (rv) void'(mem_q.pop_front());
      if (rd) begin
        if (rv) void'(m_inf.pop_front());
        foreach (m_inf[i]) m_inf[i].live = 0;
        m_buf.delete();
        m_pc = rpc;
      end else begin
        if (m_buf.size() > 0 && !s) void'(m_buf.pop_front());
        if (rv) begin
          f = m_inf.pop_front();
          if (f.live) m_buf.push_back(f.addr);
        end
        if (issue) begin
          m_inf.push_back('{addr: m_pc, live: 1'b1});
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mem_q.push_back('{addr: m_pc, due: due});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    run_cycle(1, 0, 0, 0, 1);
    run_cycle(1, 0, 0, 0, 1);
  endtask

  initial begin
    int n_iss, k;
    logic [31:0] a0;
    rst_i = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    imem_ready_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    @(posedge clk_i); #1;

    // 1: single-cycle memory streaming
    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_cycle(0, 0, 0, 0, 1);
      chk("t1_addr", o_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("t1_valid", {31'b0, o_valid}, 32'h1);
        chk("t1_pc4", o_pc4, 32'(4 * (i - 1)));
        chk("t1_instr", o_instr, data_of(32'(4 * (i - 2))));
      end
    end

    // 2: stall fills the queue, release drains in order
    do_reset();
    n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      run_cycle(0, 1, 0, 0, 1);
      if (o_req) n_iss++;
    end
    chk("t2_issues", 32'(n_iss), 32'd4);
    chk("t2_req_full", {31'b0, o_req}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 0, 0, 0, 1);
      chk("t2_drain_pc4", o_pc4, 32'(4 * (i + 1)));
    end

    // 6: reset with a full queue
    for (int i = 0; i < 6; i++) run_cycle(0, 1, 0, 0, 1);
    run_cycle(1, 1, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 1);
    chk("t6_valid", {31'b0, o_valid}, 32'h0);
    chk("t6_addr", o_addr, RST_PC);

    // 3: three-cycle memory, redirect with requests outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 0, 1, 32'h40, 1);
    k = 0;
    do begin
      run_cycle(0, 0, 0, 0, 1);
      k++;
    end while (!o_valid && k < 30);
    chk("t3_valid", {31'b0, o_valid}, 32'h1);
    chk("t3_pc4", o_pc4, 32'h44);
    chk("t3_instr", o_instr, data_of(32'h40));

    // 4: redirect coinciding with a response and a pop
    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 0, 1, 32'h100, 1);
    chk("t4_rv_and_valid", {30'b0, o_rv, o_valid}, 32'h3);
    run_cycle(0, 0, 0, 0, 1);
    chk("t4_valid", {31'b0, o_valid}, 32'h0);
    chk("t4_addr", o_addr, 32'h100);

    // 5: memory not ready holds the request
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_cycle(0, 0, 0, 0, 0);
      chk("t5_hold_addr", o_addr, 32'h0);
      chk("t5_no_valid", {31'b0, o_valid}, 32'h0);
    end
    run_cycle(0, 0, 0, 0, 1);
    run_cycle(0, 0, 0, 0, 1);
    chk("t5_next_addr", o_addr, 32'h4);

    // randomized traffic against the model
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 4000; i++) begin
      a0 = ($urandom_range(9, 0) == 0) ? 32'hFFFF_FFF0 : {$urandom, 2'b00} & 32'h0000_FFFC;
      run_cycle($urandom_range(199, 0) == 0, $urandom_range(9, 0) < 3,
                $urandom_range(19, 0) == 0, a0, $urandom_range(9, 0) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
